// File: rtl/score_pkg.sv
// Shared score definitions for score_keeper and score_sprite.
// Holds the score width, saturation limits, game state enum and saturating step helpers.
package score_pkg;

    localparam int SCORE_W   = 3;
    localparam int SCORE_MAX = 7;

    localparam logic [SCORE_W-1:0] SCORE_TOP  = SCORE_W'(SCORE_MAX);
    localparam logic [SCORE_W-1:0] SCORE_ZERO = '0;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } game_state_t;

    // One step worse, pinned at the top of the range.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_TOP) ? s : s + 1'b1;
    endfunction

    // One step better, pinned at zero.
    function automatic logic [SCORE_W-1:0] score_dec(input logic [SCORE_W-1:0] s);
        return (s == SCORE_ZERO) ? s : s - 1'b1;
    endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// Counts tick pulses and fires a single-cycle done pulse on every FRAMES-th tick.
// restart clears the count and suppresses a done that would coincide with it.
module frame_tick_counter #(
    parameter int FRAMES = 60
) (
    input  logic clk_pixel,
    input  logic rst_n_in,
    input  logic tick,
    input  logic restart,
    output logic done
);

    localparam int CNT_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAMES - 1);

    logic [CNT_W-1:0] count;

    assign done = tick && !restart && (count == LAST);

    // Tick count since the last restart, wrapping back to zero on done.
    always_ff @(posedge clk_pixel or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count <= '0;
        end else if (restart || done) begin
            count <= '0;
        end else if (tick) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Game score keeper: hits lower the score, misses raise it, saturating at 0..7.
// Reaching 7 ends the game until clear_in; score_out only changes on frame boundaries.
// Optional feature macro SCORE_DECAY_EN: score drifts down by one after DECAY_FRAMES
// frames without a miss.
module score_keeper
    import score_pkg::*;
#(
    parameter int DECAY_FRAMES = 60
) (
    input  logic               clk_pixel,
    input  logic               rst_n_in,
    input  logic               hit_in,
    input  logic               miss_in,
    input  logic               new_frame_in,
    input  logic               clear_in,
    output logic [SCORE_W-1:0] score_out,
    output logic               game_over_out
);

    if (DECAY_FRAMES < 1) begin : g_bad_decay_frames
        $error("DECAY_FRAMES must be at least 1");
    end

    game_state_t        state;
    logic [SCORE_W-1:0] live_score;
    logic [SCORE_W-1:0] event_score;
    logic [SCORE_W-1:0] live_next;
    logic               armed;
    logic               hit_ok;
    logic               miss_ok;
    logic               frame_ok;
    logic               decay_step;

    // Events sampled on the first edge after reset release belong to the partial
    // cycle in which reset was still active, so they are masked until armed is set.
    assign hit_ok   = hit_in && armed;
    assign miss_ok  = miss_in && armed;
    assign frame_ok = new_frame_in && armed;

`ifdef SCORE_DECAY_EN
    logic frame_tick;
    logic count_restart;

    assign frame_tick    = frame_ok && (state == PLAY);
    assign count_restart = miss_ok || clear_in;

    frame_tick_counter #(
        .FRAMES (DECAY_FRAMES)
    ) u_decay_counter (
        .clk_pixel (clk_pixel),
        .rst_n_in  (rst_n_in),
        .tick      (frame_tick),
        .restart   (count_restart),
        .done      (decay_step)
    );
`else
    assign decay_step = 1'b0;
`endif

    // Next live score: hit/miss step first, then any decay step; frozen once the game is over.
    always_comb begin
        event_score = live_score;
        if (miss_ok && !hit_ok) begin
            event_score = score_inc(live_score);
        end else if (hit_ok && !miss_ok) begin
            event_score = score_dec(live_score);
        end
        live_next = event_score;
        if (decay_step) begin
            live_next = score_dec(event_score);
        end
        if (state == OVER) begin
            live_next = live_score;
        end
    end

    // Game FSM with live score, frame-aligned display score and registered game-over flag.
    always_ff @(posedge clk_pixel or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= PLAY;
            live_score    <= SCORE_ZERO;
            score_out     <= SCORE_ZERO;
            game_over_out <= 1'b0;
            armed         <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (clear_in) begin
                state         <= PLAY;
                live_score    <= SCORE_ZERO;
                score_out     <= SCORE_ZERO;
                game_over_out <= 1'b0;
            end else begin
                live_score <= live_next;
                if (frame_ok) begin
                    score_out <= live_next;
                end
                case (state)
                    PLAY: begin
                        if (live_next == SCORE_TOP) begin
                            state         <= OVER;
                            game_over_out <= 1'b1;
                        end
                    end
                    OVER: begin
                        game_over_out <= 1'b1;
                    end
                    default: begin
                        state         <= PLAY;
                        game_over_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter DECAY_FRAMES, default 60, frames without a miss before one decay step (used only with SCORE_DECAY_EN).
REQ-002 SHALL have clk_pixel  input  1  the single clock; all state is on its rising edge.
REQ-003 SHALL have rst_n_in  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have hit_in  input  1  one-cycle pulse: player success, score decrements.
REQ-005 SHALL have miss_in  input  1  one-cycle pulse: player failure, score increments.
REQ-006 SHALL have new_frame_in  input  1  one-cycle pulse at start of vertical blank.
REQ-007 SHALL have clear_in  input  1  synchronous request to restart the game.
REQ-008 SHALL have score_out  output  3  frame-stable score, 0 (best) to 7 (worst), consumed by the score display sprite.
REQ-009 SHALL have game_over_out  output  1  high while in state OVER.

Function
REQ-010 SHALL keep an internal 3-bit live score, updated every cycle from the hit and miss pulses.
REQ-011 SHALL apply miss-only as live+1 and hit-only as live-1, saturating at 7 and at 0 (no wrap-around).
REQ-012 SHALL treat hit_in and miss_in high in the same cycle as no change.
REQ-013 SHALL implement a state machine with states PLAY and OVER: PLAY->OVER in the cycle the next live score equals 7; OVER->PLAY only on clear_in.
REQ-014 SHALL ignore hit_in and miss_in in OVER; live score stays at 7.
REQ-015 SHALL update score_out only on new_frame_in, loading the next live score (including events in that same cycle), visible one cycle after the pulse.
REQ-016 SHALL hold score_out constant between new_frame_in pulses so the display never changes mid-frame.
REQ-017 SHALL give clear_in priority over all events and new_frame_in: on the next edge live score=0, score_out=0 (not frame-aligned), state=PLAY, decay counter=0.
REQ-018 SHALL assert game_over_out one cycle after entering OVER and deassert it one cycle after clear_in.
REQ-019 SHALL keep score_out and live score within 0..7 under any input combination.

Reset
REQ-020 SHALL, while rst_n_in is low, asynchronously force live score=0, score_out=0, game_over_out=0, state=PLAY, decay counter=0.
REQ-021 SHALL discard any event coincident with reset assertion; the first event counted is the first full cycle after reset release.
REQ-022 SHALL, when reset is asserted mid-game (including in OVER), return to the REQ-020 values with no residual state.

Configuration
REQ-023 SHALL, when macro SCORE_DECAY_EN is defined, count new_frame_in pulses in PLAY and, after DECAY_FRAMES pulses with no miss_in, decrement live score by 1 (saturating at 0) and restart the count.
REQ-024 SHALL restart the decay count on any miss_in; hit_in does not affect it; a decay step coincident with a miss is dropped.
REQ-025 SHALL, when SCORE_DECAY_EN is undefined, include no decay counter logic; the score changes only via hit_in, miss_in and clear_in.

Structure
REQ-026 SHALL take SCORE_W=3, SCORE_MAX=7 and the state enum typedef (PLAY, OVER) from shared package score_pkg, which score_sprite also uses for its score width.
REQ-027 SHALL place the decay counter in one sub-module, frame_tick_counter (inputs tick, restart; output done pulse), instantiated only under SCORE_DECAY_EN.

Verification
REQ-028 SHALL cover: reset, 3 miss pulses, then new_frame_in -> score_out stays 0 until one cycle after new_frame_in, then 3.
REQ-029 SHALL cover: score 0, 2 hits then new_frame_in -> score_out 0 (saturation); score 6, hit+miss same cycle, new_frame_in -> score_out 6.
REQ-030 SHALL cover: score 6, miss then new_frame_in -> game_over_out=1, score_out=7; further hits -> score_out stays 7.
REQ-031 SHALL cover: in OVER, clear_in coincident with new_frame_in and a hit -> next cycle score_out=0, game_over_out=0, state PLAY.
REQ-032 SHALL cover: score 4, rst_n_in pulsed low mid-cycle -> outputs 0 immediately and asynchronously; a miss in the same cycle as release is not counted.
REQ-033 SHALL cover, with SCORE_DECAY_EN and DECAY_FRAMES=3: score 2, 3 frames with no miss -> score_out 1; a miss on frame 2 restarts the count.
